// File: rtl/mmp_iddmm_ctrl_gen.sv
// mmp_iddmm_ctrl_gen
// Loop sequencer for the interleaved Montgomery multiply PE array. It walks
// the i (row) and j (word) loops for a runtime operand length, drives the PE
// strobes and A-memory write-back, lets the PE pipeline drain, and then runs a
// request/acknowledge handshake with the final-subtract unit.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   task_req/task_len start request and word count (sampled in IDLE only)
//   abort             synchronous abort back to IDLE
//   task_busy         high whenever the sequencer is not idle
//   task_done         one-cycle pulse when the final subtract completes
//   ctl_*             registered PE control strobes
//   carry             final PE carry, captured into ref_an before the subtract
//   comp_req/comp_end final-subtract handshake
//   ref_addr_*        operand read addresses (copies of i and j)
//   ref_wr_n          registered (j == n)
//   ref_wr_a_*        A-memory write-back address and enable
module mmp_iddmm_ctrl_gen #(
  parameter int NW        = 32,
  parameter int AW        = 5,
  parameter int PIPE_LAT  = 4,
  parameter int HALF_RATE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          task_req,
  input  logic [AW:0]   task_len,
  input  logic          abort,
  output logic          task_busy,
  output logic          task_done,
  output logic          ctl_carry_clr,
  output logic          ctl_carry_ena,
  output logic          ctl_carry_sel,
  output logic          ctl_c_pre_clr,
  output logic          ctl_c_pre_ena,
  output logic          ctl_q_ena,
  input  logic          carry,
  output logic          comp_req,
  input  logic          comp_end,
  output logic          ref_an,
  output logic [AW:0]   ref_addr_rdx,
  output logic [AW-1:0] ref_addr_rdy,
  output logic [AW-1:0] ref_addr_rdm,
  output logic [AW-1:0] ref_addr_rda,
  output logic          ref_wr_n,
  output logic [AW-1:0] ref_wr_a_addr,
  output logic          ref_wr_a_ena
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_J00S,
    S_J00C,
    S_LOOP,
    S_DRAIN,
    S_FSUB
  } state_t;

  localparam logic [AW:0] N_MAX = (AW+1)'(NW);

  state_t        r_state;
  state_t        w_stateNext;
  logic [AW:0]   r_n;
  logic [AW:0]   r_j;
  logic [AW:0]   w_jNext;
  logic [AW-1:0] r_i;
  logic [AW-1:0] w_iNext;
  logic          r_j00;
  logic          w_j00Next;
  logic          r_phase;
  logic          w_phaseNext;
  logic [AW:0]   w_lenClamped;
  logic [AW:0]   w_nMinus1;
  logic          w_loopNext;
  logic          w_dlAny;

  logic [PIPE_LAT-1:0] r_dlValid;
  logic [PIPE_LAT-1:0] r_dlPhase;
  logic [AW:0]         r_dlJ [PIPE_LAT];

  logic          r_carryClr;
  logic          r_carryEna;
  logic          r_carrySel;
  logic          r_cPreClr;
  logic          r_cPreEna;
  logic          r_wrN;
  logic          r_wrEna;
  logic [AW-1:0] r_wrAddr;
  logic          r_compReq;
  logic          r_an;
  logic          r_done;

  // A zero or oversized length means "full width operand".
  assign w_lenClamped = ((task_len == '0) || (task_len > N_MAX)) ? N_MAX : task_len;
  assign w_nMinus1    = r_n - 1'b1;
  assign w_dlAny      = |r_dlValid;
  assign w_loopNext   = (w_stateNext == S_LOOP);

  // In half-rate mode the phase bit restarts at 0 at the start of every row,
  // so each j value is presented for a phase-0 and a phase-1 cycle.
  if (HALF_RATE != 0) begin : g_halfRate
    assign w_phaseNext = !(abort || (r_state == S_IDLE) || r_j00) && !r_phase;
  end else begin : g_fullRate
    assign w_phaseNext = !abort;
  end

  // Next-cycle state and loop counters. The control strobes are decoded from
  // these values so that they line up with the registered i/j/j00 copies.
  always_comb begin
    w_stateNext = r_state;
    w_iNext     = r_i;
    w_jNext     = r_j;
    w_j00Next   = r_j00;
    case (r_state)
      S_IDLE: begin
        if (task_req) w_stateNext = S_J00S;
      end
      S_J00S: begin
        w_j00Next   = 1'b1;
        w_stateNext = S_J00C;
      end
      S_J00C: begin
        w_j00Next   = 1'b0;
        w_stateNext = S_LOOP;
      end
      S_LOOP: begin
        if (r_phase) begin
          if (r_j < r_n) begin
            w_jNext = r_j + 1'b1;
          end else if ({1'b0, r_i} < w_nMinus1) begin
            w_jNext     = '0;
            w_iNext     = r_i + 1'b1;
            w_j00Next   = 1'b1;
            w_stateNext = S_J00C;
          end else begin
            w_jNext     = '0;
            w_iNext     = '0;
            w_stateNext = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!w_dlAny) w_stateNext = S_FSUB;
      end
      S_FSUB: begin
        if (comp_end) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (abort) begin
      w_stateNext = S_IDLE;
      w_iNext     = '0;
      w_jNext     = '0;
      w_j00Next   = 1'b0;
    end
  end

  // Sequencer registers, PE delay line and all registered outputs. The delay
  // line mirrors the PE latency so write-back follows the data it belongs to;
  // abort flushes it so no stale write reaches the A memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_j00      <= 1'b0;
      r_phase    <= 1'b0;
      r_dlValid  <= '0;
      r_dlPhase  <= '0;
      for (int s = 0; s < PIPE_LAT; s++) r_dlJ[s] <= '0;
      r_carryClr <= 1'b0;
      r_carryEna <= 1'b0;
      r_carrySel <= 1'b0;
      r_cPreClr  <= 1'b0;
      r_cPreEna  <= 1'b0;
      r_wrN      <= 1'b0;
      r_wrEna    <= 1'b0;
      r_wrAddr   <= '0;
      r_compReq  <= 1'b0;
      r_an       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_i     <= w_iNext;
      r_j     <= w_jNext;
      r_j00   <= w_j00Next;
      r_phase <= w_phaseNext;

      if ((r_state == S_IDLE) && task_req && !abort) r_n <= w_lenClamped;

      r_dlValid[0] <= !abort && (r_state == S_LOOP);
      r_dlPhase[0] <= r_phase;
      r_dlJ[0]     <= r_j;
      for (int s = 1; s < PIPE_LAT; s++) begin
        r_dlValid[s] <= !abort && r_dlValid[s-1];
        r_dlPhase[s] <= r_dlPhase[s-1];
        r_dlJ[s]     <= r_dlJ[s-1];
      end

      r_carryClr <= w_loopNext && (w_jNext == '0) && (w_iNext == '0);
      r_carryEna <= w_loopNext && (w_jNext == r_n) && w_phaseNext;
      r_carrySel <= w_loopNext && (w_jNext == r_n);
      r_wrN      <= w_loopNext && (w_jNext == r_n);
      r_cPreClr  <= (w_jNext == '0) && w_j00Next;
      r_cPreEna  <= w_phaseNext;

      // j == 0 is the carry-in slot of a row and produces no result word.
      r_wrEna  <= !abort && r_dlValid[PIPE_LAT-1] && (r_dlJ[PIPE_LAT-1] != '0)
                  && r_dlPhase[PIPE_LAT-1];
      r_wrAddr <= r_dlJ[PIPE_LAT-1][AW-1:0] - 1'b1;

      if (abort) begin
        r_compReq <= 1'b0;
      end else if ((r_state == S_DRAIN) && !w_dlAny) begin
        r_an      <= carry;
        r_compReq <= 1'b1;
      end else if ((r_state == S_FSUB) && comp_end) begin
        r_compReq <= 1'b0;
      end
      r_done <= !abort && (r_state == S_FSUB) && comp_end;
    end
  end

  assign task_busy     = (r_state != S_IDLE);
  assign task_done     = r_done;
  assign ctl_carry_clr = r_carryClr;
  assign ctl_carry_ena = r_carryEna;
  assign ctl_carry_sel = r_carrySel;
  assign ctl_c_pre_clr = r_cPreClr;
  assign ctl_c_pre_ena = r_cPreEna;
  assign ctl_q_ena     = r_cPreClr;
  assign comp_req      = r_compReq;
  assign ref_an        = r_an;
  assign ref_addr_rdx  = r_j;
  assign ref_addr_rdy  = r_i;
  assign ref_addr_rdm  = r_j[AW-1:0];
  assign ref_addr_rda  = r_j[AW-1:0];
  assign ref_wr_n      = r_wrN;
  assign ref_wr_a_addr = r_wrAddr;
  assign ref_wr_a_ena  = r_wrEna;

endmodule

// File: tb/tb_mmp_iddmm_ctrl_gen.sv
// tb_mmp_iddmm_ctrl_gen
// Bench for mmp_iddmm_ctrl_gen. One full-rate and one half-rate instance share
// the stimulus; curHalf selects which one is started and observed. A loop-level
// model builds the expected per-cycle timeline of every task and a compare
// process checks the selected instance against it on every falling edge.
module tb_mmp_iddmm_ctrl_gen;

  localparam int NW   = 32;
  localparam int AW   = 5;
  localparam int PL   = 4;
  localparam int MAXC = 1200;

  logic        clk = 1'b0;
  logic        rst;
  logic        taskReq;
  logic [AW:0] taskLen;
  logic        abort;
  logic        carry;
  logic        compEnd;
  bit          curHalf;
  logic        reqF;
  logic        reqH;

  logic fBusy, fDone, fClr, fEna, fSel, fPreClr, fPreEna, fQEna, fReq, fAn, fWrN, fWrEna;
  logic hBusy, hDone, hClr, hEna, hSel, hPreClr, hPreEna, hQEna, hReq, hAn, hWrN, hWrEna;
  logic sBusy, sDone, sClr, sEna, sSel, sPreClr, sPreEna, sQEna, sReq, sAn, sWrN, sWrEna;
  logic [AW:0]   fRdx, hRdx, sRdx;
  logic [AW-1:0] fRdy, hRdy, sRdy, fRdm, hRdm, sRdm, fRda, hRda, sRda;
  logic [AW-1:0] fWa, hWa, sWa;
  logic [37:0]   fOut, hOut, sOut;

  always #5 clk = ~clk;

  assign reqF = taskReq & ~curHalf;
  assign reqH = taskReq & curHalf;

  mmp_iddmm_ctrl_gen #(.NW(NW), .AW(AW), .PIPE_LAT(PL), .HALF_RATE(0)) dutF (
    .clk(clk), .rst(rst), .task_req(reqF), .task_len(taskLen), .abort(abort),
    .task_busy(fBusy), .task_done(fDone), .ctl_carry_clr(fClr), .ctl_carry_ena(fEna),
    .ctl_carry_sel(fSel), .ctl_c_pre_clr(fPreClr), .ctl_c_pre_ena(fPreEna),
    .ctl_q_ena(fQEna), .carry(carry), .comp_req(fReq), .comp_end(compEnd),
    .ref_an(fAn), .ref_addr_rdx(fRdx), .ref_addr_rdy(fRdy), .ref_addr_rdm(fRdm),
    .ref_addr_rda(fRda), .ref_wr_n(fWrN), .ref_wr_a_addr(fWa), .ref_wr_a_ena(fWrEna)
  );

  mmp_iddmm_ctrl_gen #(.NW(NW), .AW(AW), .PIPE_LAT(PL), .HALF_RATE(1)) dutH (
    .clk(clk), .rst(rst), .task_req(reqH), .task_len(taskLen), .abort(abort),
    .task_busy(hBusy), .task_done(hDone), .ctl_carry_clr(hClr), .ctl_carry_ena(hEna),
    .ctl_carry_sel(hSel), .ctl_c_pre_clr(hPreClr), .ctl_c_pre_ena(hPreEna),
    .ctl_q_ena(hQEna), .carry(carry), .comp_req(hReq), .comp_end(compEnd),
    .ref_an(hAn), .ref_addr_rdx(hRdx), .ref_addr_rdy(hRdy), .ref_addr_rdm(hRdm),
    .ref_addr_rda(hRda), .ref_wr_n(hWrN), .ref_wr_a_addr(hWa), .ref_wr_a_ena(hWrEna)
  );

  assign fOut = {fBusy, fDone, fClr, fEna, fSel, fPreClr, fPreEna, fQEna, fReq, fAn, fWrN, fWrEna,
                 fRdx, fRdy, fRdm, fRda, fWa};
  assign hOut = {hBusy, hDone, hClr, hEna, hSel, hPreClr, hPreEna, hQEna, hReq, hAn, hWrN, hWrEna,
                 hRdx, hRdy, hRdm, hRda, hWa};
  assign sOut = curHalf ? hOut : fOut;
  assign {sBusy, sDone, sClr, sEna, sSel, sPreClr, sPreEna, sQEna, sReq, sAn, sWrN, sWrEna,
          sRdx, sRdy, sRdm, sRda, sWa} = sOut;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    else
      passCount++;
  endtask

  // Expected timeline, index 0 is the first cycle after the accepted request.
  logic [AW-1:0] mI   [MAXC];
  logic [AW:0]   mJ   [MAXC];
  bit            mJ00 [MAXC];
  bit            mLoop[MAXC];
  bit            mPh  [MAXC];
  bit            mWr  [MAXC];
  logic [AW-1:0] mWa  [MAXC];
  int  modelN, modelLastLoop, modelEnd, modelWrites, modelClr;
  int  modelK;
  bit  modelActive;
  bit  modelAn;

  // Row structure: one j00 cycle, then j = 0..n, each held for 1 or 2 cycles.
  // A result word leaves the PE pipeline PIPE_LAT+1 cycles after its j slot.
  task automatic buildModel(input int n, input bit half);
    int k;
    int reps;
    for (int x = 0; x < MAXC; x++) begin
      mI[x] = '0; mJ[x] = '0; mJ00[x] = 0; mLoop[x] = 0; mPh[x] = 0; mWr[x] = 0; mWa[x] = '0;
    end
    reps = half ? 2 : 1;
    k = 0;
    for (int r = 0; r < n; r++) begin
      k++;
      mI[k] = AW'(r);
      mJ00[k] = 1;
      for (int j = 0; j <= n; j++) begin
        for (int s = 0; s < reps; s++) begin
          k++;
          mLoop[k] = 1;
          mI[k] = AW'(r);
          mJ[k] = (AW+1)'(j);
          mPh[k] = half ? (s == 1) : 1'b1;
        end
      end
    end
    modelN = n;
    modelLastLoop = k;
    modelEnd = k + PL + 2;
    modelWrites = 0;
    modelClr = 0;
    for (int x = 1; x <= modelLastLoop; x++) begin
      if (mLoop[x] && mI[x] == 0 && mJ[x] == 0) modelClr++;
      if (mLoop[x] && mJ[x] != 0 && mPh[x]) begin
        mWr[x + PL + 1] = 1;
        mWa[x + PL + 1] = AW'(mJ[x] - 1);
        modelWrites++;
      end
    end
  endtask

  // Per-cycle comparison of the selected instance against the timeline.
  int cmpK;
  always @(negedge clk) begin
    if (modelActive) begin
      cmpK = modelK;
      if (cmpK < modelEnd) begin
        checkOutput("busy", sBusy, 1);
        checkOutput("done", sDone, 0);
        checkOutput("compReq", sReq, 0);
        checkOutput("addrRdy", sRdy, mI[cmpK]);
        checkOutput("addrRdx", sRdx, mJ[cmpK]);
        checkOutput("addrRdm", sRdm, mJ[cmpK][AW-1:0]);
        checkOutput("addrRda", sRda, mJ[cmpK][AW-1:0]);
        checkOutput("carryClr", sClr, mLoop[cmpK] && mI[cmpK] == 0 && mJ[cmpK] == 0);
        checkOutput("carrySel", sSel, mLoop[cmpK] && mJ[cmpK] == modelN);
        checkOutput("wrN", sWrN, mLoop[cmpK] && mJ[cmpK] == modelN);
        checkOutput("carryEna", sEna, mLoop[cmpK] && mJ[cmpK] == modelN && mPh[cmpK]);
        checkOutput("cPreClr", sPreClr, mJ00[cmpK] && mJ[cmpK] == 0);
        checkOutput("qEna", sQEna, mJ00[cmpK] && mJ[cmpK] == 0);
        if (mLoop[cmpK]) checkOutput("cPreEna", sPreEna, mPh[cmpK]);
        checkOutput("wrEna", sWrEna, mWr[cmpK]);
        if (mWr[cmpK]) checkOutput("wrAddr", sWa, mWa[cmpK]);
      end else begin
        checkOutput("compReqRise", sReq, 1);
        checkOutput("refAn", sAn, modelAn);
        modelActive = 0;
      end
      modelK = modelK + 1;
    end
  end

  // Event counters used by the end-of-task checks.
  int wrCount, clrCount, enaCount, reqCycles, doneCount;
  logic [AW-1:0] lastAddr;
  always @(negedge clk) begin
    if (sWrEna) begin
      wrCount++;
      lastAddr = sWa;
    end
    if (sClr) clrCount++;
    if (sEna) enaCount++;
    if (sReq) reqCycles++;
    if (sDone) doneCount++;
  end

  task automatic applyStimulus(input int len);
    @(posedge clk);
    #1;
    taskLen = (AW+1)'(len);
    taskReq = 1'b1;
    wrCount = 0; clrCount = 0; enaCount = 0; reqCycles = 0; doneCount = 0; lastAddr = '0;
    @(posedge clk);
    #1;
    taskReq = 1'b0;
    modelK = 0;
    modelActive = 1;
  endtask

  // Returns one cycle after the first comp_req cycle.
  task automatic waitWindow();
    for (int t = 0; t < 3000 && modelActive; t++) @(posedge clk);
    #1;
    if (modelActive) begin
      checkOutput("windowTimeout", 1, 0);
      modelActive = 0;
    end
  endtask

  // Acknowledge so that comp_req stays high for exactly five cycles.
  task automatic finishFsub();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    compEnd = 1'b1;
    @(posedge clk);
    #1;
    compEnd = 1'b0;
    checkOutput("donePulse", sDone, 1);
    checkOutput("busyAfterDone", sBusy, 0);
    checkOutput("compReqAfterEnd", sReq, 0);
    @(posedge clk);
    #1;
    checkOutput("doneOneCycle", sDone, 0);
    checkOutput("compReqCycles", reqCycles, 5);
    checkOutput("doneCount", doneCount, 1);
  endtask

  int snapWr;

  initial begin
    rst = 0; taskReq = 0; taskLen = '0; abort = 0; carry = 0; compEnd = 0;
    curHalf = 0; modelActive = 0; modelK = 0; modelAn = 0;
    #2 rst = 1;
    #1;
    checkOutput("resetOutF", fOut, 0);
    checkOutput("resetOutH", hOut, 0);
    @(negedge clk);
    rst = 0;

    $display("[TB] reset in the middle of a row");
    buildModel(4, 0);
    applyStimulus(4);
    repeat (10) @(posedge clk);
    #2;
    modelActive = 0;
    rst = 1;
    #1;
    checkOutput("midResetOut", fOut, 0);
    checkOutput("midResetBusy", fBusy, 0);
    @(negedge clk);
    rst = 0;

    $display("[TB] full rate, n=4");
    carry = 1; modelAn = 1;
    buildModel(4, 0);
    checkOutput("modelRowCycles4", modelLastLoop, 24);
    checkOutput("modelWrites4", modelWrites, 16);
    checkOutput("modelClr4", modelClr, 1);
    applyStimulus(4);
    waitWindow();
    checkOutput("writes4", wrCount, 16);
    checkOutput("lastAddr4", lastAddr, 3);
    checkOutput("carryClrOnce", clrCount, 1);
    finishFsub();

    $display("[TB] half rate, n=2");
    curHalf = 1; carry = 0; modelAn = 0;
    buildModel(2, 1);
    checkOutput("modelRowCyclesH", modelLastLoop, 14);
    checkOutput("modelWritesH", modelWrites, 4);
    applyStimulus(2);
    waitWindow();
    checkOutput("writesH", wrCount, 4);
    checkOutput("lastAddrH", lastAddr, 1);
    checkOutput("carryEnaH", enaCount, 2);
    finishFsub();

    $display("[TB] length 0 maps to full width");
    curHalf = 0; carry = 0; modelAn = 0;
    buildModel(NW, 0);
    checkOutput("modelWrites32", modelWrites, 1024);
    applyStimulus(0);
    waitWindow();
    checkOutput("writes32", wrCount, 1024);
    checkOutput("lastAddr32", lastAddr, 31);
    finishFsub();

    $display("[TB] request during loop, abort with comp_end");
    carry = 1; modelAn = 1;
    buildModel(3, 0);
    applyStimulus(3);
    repeat (6) @(posedge clk);
    #1;
    taskLen = 1; taskReq = 1;
    @(posedge clk);
    #1;
    taskReq = 0;
    waitWindow();
    checkOutput("writes3", wrCount, 9);
    @(posedge clk);
    #1;
    abort = 1; compEnd = 1; carry = 0;
    @(posedge clk);
    #1;
    abort = 0; compEnd = 0;
    checkOutput("abortBusy", sBusy, 0);
    checkOutput("abortCompReq", sReq, 0);
    checkOutput("abortNoDone", sDone, 0);
    checkOutput("abortAnHeld", sAn, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abortDoneCount", doneCount, 0);
    checkOutput("abortStillIdle", sBusy, 0);

    $display("[TB] abort in the middle of a row");
    buildModel(4, 0);
    applyStimulus(4);
    repeat (8) @(posedge clk);
    #1;
    modelActive = 0;
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    checkOutput("midAbortBusy", sBusy, 0);
    checkOutput("midAbortRdx", sRdx, 0);
    checkOutput("midAbortWrEna", sWrEna, 0);
    snapWr = wrCount;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midAbortNoWrites", wrCount, snapWr);

    $display("[TB] abort together with a request");
    @(posedge clk);
    #1;
    abort = 1; taskReq = 1; taskLen = 4;
    @(posedge clk);
    #1;
    abort = 0; taskReq = 0;
    checkOutput("abortReqIdle", sBusy, 0);
    @(posedge clk);
    #1;
    checkOutput("abortReqIdle2", sBusy, 0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mmp_iddmm_ctrl_gen.md
Name: mmp_iddmm_ctrl_gen

Overview:
- Parametrised successor of the IDDMM PE controller.
- Sequences the i/j loops of the interleaved Montgomery multiply for a runtime-selectable operand length, up to NW words.
- Drives PE strobes and A-memory write-back, then hands off to the final-subtract unit.
- Adds over the previous generation: runtime length, full/half-rate mode, a valid-tracked pipeline drain, abort, and busy/done status.

Parameters:
- NW, 32, maximum words per operand (power of 2, 4..256).
- AW, 5, address width; must equal log2(NW).
- PIPE_LAT, 4, PE datapath latency (L1+L2+L3+L4), at least 1.
- HALF_RATE, 0, 0: j advances every cycle. 1: j advances every 2 cycles, for the 2-cycle final adder.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- task_req  in  1  start request; sampled only in IDLE.
- task_len  in  AW+1  word count n; captured with task_req.
- abort  in  1  synchronous abort.
- task_busy  out  1  high in any state except IDLE.
- task_done  out  1  one-cycle pulse when FSUB completes.
- ctl_carry_clr  out  1  registered (j==0 && i==0).
- ctl_carry_ena  out  1  registered (j==n && phase).
- ctl_carry_sel  out  1  registered (j==n).
- ctl_c_pre_clr  out  1  registered (j==0 && j00).
- ctl_c_pre_ena  out  1  registered phase bit.
- ctl_q_ena  out  1  equals ctl_c_pre_clr.
- carry  in  1  PE final carry.
- comp_req  out  1  final-subtract request (level).
- comp_end  in  1  final-subtract done.
- ref_an  out  1  captured top carry.
- ref_addr_rdx  out  AW+1  equals j.
- ref_addr_rdy  out  AW  equals i.
- ref_addr_rdm  out  AW  equals j[AW-1:0].
- ref_addr_rda  out  AW  equals j[AW-1:0].
- ref_wr_n  out  1  registered (j==n).
- ref_wr_a_addr  out  AW  (jd-1)[AW-1:0].
- ref_wr_a_ena  out  1  A-memory write enable.

Behaviour:
- Reset: all outputs, counters, state and delay line go to 0 asynchronously on rst=1.
- Length capture: on task_req in IDLE, n is latched. n=0 or n>NW is clamped to NW. n stays fixed for the whole task.
- Phase bit: constant 1 when HALF_RATE=0. When HALF_RATE=1 it is cleared whenever j00=1 and toggles every other cycle.
- FSM states: IDLE, J00S, J00C, LOOP, DRAIN, FSUB.
  - IDLE: task_req moves to J00S on the next cycle. task_req in any other state is ignored.
  - J00S: sets j00=1, moves to J00C.
  - J00C: clears j00, moves to LOOP.
  - LOOP: j advances only when phase=1.
    - If j<n: j+1.
    - If j==n and i<n-1: j=0, i+1, j00=1, move to J00C.
    - If j==n and i==n-1: clear i and j, move to DRAIN.
  - DRAIN: waits until the delay line holds no valid entry. On that cycle ref_an<=carry, comp_req<=1, move to FSUB.
  - FSUB: on comp_end, comp_req<=0 and task_done=1 for one cycle, move to IDLE.
- Registered strobes: all ctl_* and ref_wr_n are decoded from the next-cycle counter values and registered, so they align with the registered copies of i, j and j00.
- Delay line: PIPE_LAT stages of {valid, phase, j}. valid=1 is injected only in LOOP. The output is jd/phd/vd.
  - ref_wr_a_ena = vd && jd!=0 && phd.
  - Each row produces exactly n writes, at addresses 0..n-1.
- Cycle count (HALF_RATE=0): LOOP plus J00C totals n*(n+2) cycles after J00S. The last write occurs PIPE_LAT+1 cycles after the final j==n.
- Abort: abort=1 in any state returns to IDLE on the next edge. It clears i, j, j00, phase, comp_req and all delay-line valid bits; ref_an is held.
  - No task_done is issued.
  - Abort together with comp_end: abort wins.
  - Abort together with task_req in IDLE: stays in IDLE.

Test Plan:
- rst pulse mid-LOOP with n=4 -> every output 0 immediately; task_busy=0; a fresh task_req then starts cleanly from i=j=0.
- NW=32, PIPE_LAT=4, HALF_RATE=0, task_len=4 -> LOOP+J00C lasts 24 cycles; 16 ref_wr_a_ena pulses with addresses 0,1,2,3 repeated four times; ctl_carry_clr high exactly once.
- Same setup with carry=1 during DRAIN, comp_end asserted 5 cycles after comp_req -> ref_an=1; comp_req high 5 cycles; one task_done pulse; task_busy low on the following cycle.
- HALF_RATE=1, task_len=2 -> each j held 2 cycles; ctl_c_pre_ena alternates 0/1; 4 writes total at addresses 0,1,0,1; ctl_carry_ena high only on the phase=1 cycle of j==2.
- task_len=0 -> behaves as n=32: 1024 writes, last address 31.
- abort raised in FSUB together with comp_end -> IDLE next cycle, no task_done, comp_req=0; task_req during LOOP is ignored and the count is unchanged.
